// File: rtl/sha256_multi_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha256_multi_block                                           |
// | Description : Multi-block SHA-256 engine with in-line padding, optional    |
// |               double hash, memory-mapped message read and digest write.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sha256_multi_block #(
    parameter int NUM_OF_WORDS = 20,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              double_hash,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              done,
    output logic              busy,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    localparam int c_num_blocks = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [7:0]  c_last_blk = 8'(c_num_blocks - 1);
    localparam logic [15:0] c_n        = 16'(NUM_OF_WORDS);
    localparam logic [31:0] c_iv [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_COMPUTE = 3'd2,
        S_UPDATE  = 3'd3,
        S_PASS2   = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        blk_q, blk_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              pass2_q, pass2_d, dh_q, dh_d;
    logic [ADDR_W-1:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0]       h_q [8], h_d [8], v_q [8], v_d [8], w_q [16], w_d [16];
    logic              done_q, done_d, busy_q, busy_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [31:0] t1, t2, w_new, pad_word;
    logic [31:0] hn [8];
    logic [15:0] g_blk, g_cap, g_iss, g_nxt;

    always_comb begin
        t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + c_k[cnt_q[5:0]] + w_q[0];
        t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
        for (int i = 0; i < 8; i++) hn[i] = h_q[i] + v_q[i];
        // Capture in READ cycle c belongs to word t = c-1; the issue is for t = c+1.
        g_blk = {4'd0, blk_q, 4'd0};
        g_cap = g_blk + 16'(cnt_q) - 16'd1;
        g_iss = g_blk + 16'(cnt_q) + 16'd1;
        g_nxt = g_blk + 16'd16;
        if (g_cap < c_n)                               pad_word = mem_read_data;
        else if (g_cap == c_n)                         pad_word = 32'h80000000;
        else if (blk_q == c_last_blk && cnt_q == 7'd16) pad_word = 32'(NUM_OF_WORDS * 32);
        else                                           pad_word = 32'd0;
    end

    always_comb begin
        state_d = state_q;  blk_d = blk_q;  cnt_d = cnt_q;
        pass2_d = pass2_q;  dh_d = dh_q;
        msg_addr_d = msg_addr_q;  out_addr_d = out_addr_q;
        h_d = h_q;  v_d = v_q;  w_d = w_q;
        done_d = 1'b0;  busy_d = busy_q;  mem_we_d = mem_we_q;
        mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: if (start) begin
                h_d = c_iv;  dh_d = double_hash;
                msg_addr_d = message_addr;  out_addr_d = output_addr;
                blk_d = 8'd0;  cnt_d = 7'd0;  pass2_d = 1'b0;  busy_d = 1'b1;
                mem_addr_d = message_addr;
                state_d = S_READ;
            end
            S_READ: begin
                if (cnt_q != 7'd0) begin
                    for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                    w_d[15] = pad_word;
                end
                // Past the message end the last address is held, so no read overruns it.
                if (cnt_q < 7'd15 && g_iss < c_n) mem_addr_d = msg_addr_q + ADDR_W'(g_iss);
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd16) begin
                    v_d = h_q;  cnt_d = 7'd0;  state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                for (int i = 7; i > 0; i--) v_d[i] = v_q[i-1];
                v_d[4] = v_q[3] + t1;
                v_d[0] = t1 + t2;
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd63) begin
                    cnt_d = 7'd0;  state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                h_d = hn;  cnt_d = 7'd0;
                if (blk_q < c_last_blk) begin
                    blk_d = blk_q + 8'd1;  state_d = S_READ;
                    if (g_nxt < c_n) mem_addr_d = msg_addr_q + ADDR_W'(g_nxt);
                end else if (dh_q && !pass2_q) begin
                    state_d = S_PASS2;
                end else begin
                    mem_we_d = 1'b1;  mem_addr_d = out_addr_q;  mem_wdata_d = hn[0];
                    state_d = S_WRITE;
                end
            end
            S_PASS2: begin
                for (int i = 0; i < 8; i++) w_d[i] = h_q[i];
                w_d[8] = 32'h80000000;
                for (int i = 9; i < 15; i++) w_d[i] = 32'd0;
                w_d[15] = 32'd256;
                h_d = c_iv;  v_d = c_iv;  pass2_d = 1'b1;  cnt_d = 7'd0;
                state_d = S_COMPUTE;
            end
            S_WRITE: begin
                if (cnt_q == 7'd7) begin
                    mem_we_d = 1'b0;  done_d = 1'b1;  state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    mem_addr_d = out_addr_q + ADDR_W'(cnt_q + 7'd1);
                    mem_wdata_d = h_q[cnt_q[2:0] + 3'd1];
                end
            end
            S_DONE: begin
                busy_d = 1'b0;  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;  blk_q <= '0;  cnt_q <= '0;
            pass2_q <= 1'b0;  dh_q <= 1'b0;
            msg_addr_q <= '0;  out_addr_q <= '0;
            h_q <= '{default: '0};  v_q <= '{default: '0};  w_q <= '{default: '0};
            done_q <= 1'b0;  busy_q <= 1'b0;  mem_we_q <= 1'b0;
            mem_addr_q <= '0;  mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;  blk_q <= blk_d;  cnt_q <= cnt_d;
            pass2_q <= pass2_d;  dh_q <= dh_d;
            msg_addr_q <= msg_addr_d;  out_addr_q <= out_addr_d;
            h_q <= h_d;  v_q <= v_d;  w_q <= w_d;
            done_q <= done_d;  busy_q <= busy_d;  mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_clk        = clk;
    assign done           = done_q;
    assign busy           = busy_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_sha256_multi_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sha256_multi_block                                        |
// | Description : Scoreboard bench for sha256_multi_block over several lengths.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sha256_multi_block;
    localparam int c_nd = 5;
    localparam int c_ns [c_nd] = '{1, 20, 13, 14, 16};
    localparam logic [31:0] c_iv [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, double_hash = 1'b0;
    logic [15:0] message_addr = '0, output_addr = '0;
    logic [31:0] mem_read_data = '0;
    int          sel = 0;
    logic        done_v [c_nd], busy_v [c_nd], mclk_v [c_nd], we_v [c_nd];
    logic [15:0] addr_v [c_nd];
    logic [31:0] wd_v [c_nd];

    always #5 clk = ~clk;

    for (genvar i = 0; i < c_nd; i++) begin : g_dut
        sha256_multi_block #(.NUM_OF_WORDS(c_ns[i]), .ADDR_W(16)) u_dut (
            .clk(clk), .reset(rst), .start(start && (sel == i)), .double_hash(double_hash),
            .message_addr(message_addr), .output_addr(output_addr),
            .done(done_v[i]), .busy(busy_v[i]), .mem_clk(mclk_v[i]), .mem_we(we_v[i]),
            .mem_addr(addr_v[i]), .mem_write_data(wd_v[i]), .mem_read_data(mem_read_data));
    end

    logic        done_s, busy_s, mclk_s, we_s;
    logic [15:0] addr_s;
    logic [31:0] wd_s;
    assign done_s = done_v[sel];
    assign busy_s = busy_v[sel];
    assign mclk_s = mclk_v[sel];
    assign we_s   = we_v[sel];
    assign addr_s = addr_v[sel];
    assign wd_s   = wd_v[sel];

    logic [31:0] mem [65536];
    always @(posedge mclk_s) begin
        mem_read_data <= mem[addr_s];
        if (we_s) mem[addr_s] = wd_s;
    end

    int          n_vec = 0, n_err = 0, cyc = 0;
    int          we_cnt = 0, done_cnt = 0, done_cyc = 0, rd_viol = 0;
    int          start_cyc = 0, job_done0 = 0, cur_n = 1;
    logic [15:0] cur_base = '0;
    logic [47:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hs, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hs;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + c_k[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g;  g = f;  f = e;  e = d + t1;
            d = c;  c = b;  b = a;  a = t1 + t2;
        end
        return {hs[255:224] + a, hs[223:192] + b, hs[191:160] + c, hs[159:128] + d,
                hs[127:96] + e,  hs[95:64] + f,   hs[63:32] + g,   hs[31:0] + h};
    endfunction

    // Reference digest of n words at base (16-bit wrapping), standard SHA-256 padding.
    function automatic logic [255:0] sha_mem(input int n, input logic [15:0] base, input logic dh);
        logic [255:0] iv, hs;
        logic [511:0] blk;
        int nb, g;
        iv = {c_iv[0], c_iv[1], c_iv[2], c_iv[3], c_iv[4], c_iv[5], c_iv[6], c_iv[7]};
        hs = iv;
        nb = (n * 32 + 64) / 512 + 1;
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 16; t++) begin
                g = 16 * b + t;
                if (g < n)                blk[511-32*t -: 32] = mem[16'(base + 16'(g))];
                else if (g == n)          blk[511-32*t -: 32] = 32'h80000000;
                else if (g == 16 * nb - 1) blk[511-32*t -: 32] = 32'(n * 32);
                else                      blk[511-32*t -: 32] = 32'd0;
            end
            hs = compress(hs, blk);
        end
        if (dh) hs = compress(iv, {hs, 32'h80000000, 192'd0, 32'd256});
        return hs;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [47:0] e;
        if (we_s) begin
            we_cnt++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 48'hx;
            chk("write", {16'h0, addr_s, wd_s}, {16'h0, e});
        end
        if (done_s) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_s && !we_s && !done_s && (16'(addr_s - cur_base) >= 16'(cur_n))) rd_viol++;
    end

    task automatic fill(input logic [15:0] base, input int n);
        for (int i = 0; i < n + 8; i++) mem[16'(base + 16'(i))] = $urandom;
    endtask

    task automatic launch(input int idx, input logic [15:0] base, input logic [15:0] outa,
                          input logic dh, input logic [255:0] dig);
        @(negedge clk);
        sel = idx;  cur_base = base;  cur_n = c_ns[idx];
        we_cnt = 0;  rd_viol = 0;  job_done0 = done_cnt;
        for (int k = 0; k < 8; k++) exp_q.push_back({16'(outa + 16'(k)), dig[255-32*k -: 32]});
        start = 1'b1;  message_addr = base;  output_addr = outa;  double_hash = dh;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    // Latency counts edges from the one sampling start to the one sampling done high.
    task automatic finish_job(input string tag, input int exp_lat);
        int c = 0;
        while (done_cnt == job_done0 && c < 800) begin
            @(posedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt - job_done0), 64'd1);
        chk({tag, "_latency"}, 64'(done_cyc + 1 - start_cyc), 64'(exp_lat));
        chk({tag, "_we_cycles"}, 64'(we_cnt), 64'd8);
        chk({tag, "_read_bound"}, 64'(rd_viol), 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_abort(input string tag);
        int d0, w0;
        #1 rst = 1'b1;
        #1;
        chk({tag, "_busy"}, 64'(busy_s), 64'd0);
        chk({tag, "_we"}, 64'(we_s), 64'd0);
        chk({tag, "_done"}, 64'(done_s), 64'd0);
        chk({tag, "_addr"}, 64'(addr_s), 64'd0);
        chk({tag, "_wdata"}, 64'(wd_s), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt;  w0 = we_cnt;
        repeat (300) @(posedge clk);
        chk({tag, "_no_done"}, 64'(done_cnt - d0), 64'd0);
        chk({tag, "_no_write"}, 64'(we_cnt - w0), 64'd0);
    endtask

    initial begin
        int c, d_before;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_s), 64'd0);
        chk("rst_we", 64'(we_s), 64'd0);
        chk("rst_done", 64'(done_s), 64'd0);
        chk("rst_addr", 64'(addr_s), 64'd0);
        rst = 1'b0;

        fill(16'h0040, 1);
        mem[16'h0040] = 32'h61626364;
        launch(0, 16'h0040, 16'h0200, 1'b0,
               256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589);
        finish_job("abcd", 91);

        fill(16'h1000, 20);
        launch(1, 16'h1000, 16'h2000, 1'b0, sha_mem(20, 16'h1000, 1'b0));
        finish_job("n20_single", 173);
        launch(1, 16'h1000, 16'h2100, 1'b1, sha_mem(20, 16'h1000, 1'b1));
        finish_job("n20_double", 239);

        fill(16'h3000, 13);
        launch(2, 16'h3000, 16'h3800, 1'b0, sha_mem(13, 16'h3000, 1'b0));
        finish_job("n13", 91);
        fill(16'h3100, 14);
        launch(3, 16'h3100, 16'h3900, 1'b0, sha_mem(14, 16'h3100, 1'b0));
        finish_job("n14", 173);
        fill(16'h3200, 16);
        launch(4, 16'h3200, 16'h3a00, 1'b1, sha_mem(16, 16'h3200, 1'b1));
        finish_job("n16_double", 239);

        fill(16'hFFF0, 20);
        launch(1, 16'hFFF0, 16'hFFFE, 1'b0, sha_mem(20, 16'hFFF0, 1'b0));
        finish_job("wrap", 173);

        d_before = done_cnt;
        launch(1, 16'h1000, 16'h2400, 1'b0, sha_mem(20, 16'h1000, 1'b0));
        repeat (40) @(posedge clk);
        #1 start = 1'b1;  message_addr = 16'h5000;  output_addr = 16'h6000;
        @(posedge clk);
        #1 start = 1'b0;
        finish_job("restart_ignored", 173);
        repeat (250) @(posedge clk);
        chk("restart_one_done", 64'(done_cnt - d_before), 64'd1);

        launch(1, 16'h1000, 16'h2800, 1'b0, sha_mem(20, 16'h1000, 1'b0));
        repeat (30) @(posedge clk);
        reset_abort("rst_compute");

        launch(1, 16'h1000, 16'h2800, 1'b0, sha_mem(20, 16'h1000, 1'b0));
        c = 0;
        while (we_cnt < 3 && c < 400) begin
            @(posedge clk);
            c++;
        end
        chk("reach_write", 64'(we_cnt >= 3), 64'd1);
        reset_abort("rst_write");

        launch(1, 16'h1000, 16'h2c00, 1'b1, sha_mem(20, 16'h1000, 1'b1));
        finish_job("after_reset", 239);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
